// File: rtl/alu_issue_stage.sv
// alu_issue_stage: single-entry ALU issue stage with valid/ready handshakes on
// both sides. A bundle is latched in IDLE (or in HOLD while the previous result
// drains), evaluated in a one-cycle EXEC state and presented in HOLD until the
// consumer takes it.
//
// Optional feature macro: ALU_SLT_OVF_CORRECT_EN
//   defined   : SLT bit0 = diff[31] ^ signed overflow (true signed compare)
//   undefined : SLT bit0 = diff[31] (raw sign of the difference)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | empty; in_ready=1, waiting for an input bundle
// EXEC  | latched bundle is evaluated; result registered on exit
// HOLD  | result presented (out_valid=1); in_ready follows out_ready
module alu_issue_stage (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_zero,
    output logic        out_ovf
);

    typedef enum logic [1:0] {
        st_idle,
        st_exec,
        st_hold
    } state_t;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_SLT  = 3'b110;
    localparam logic [2:0] OP_SLTU = 3'b111;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        accept;

    logic [31:0] sum;
    logic [32:0] diff_ext;
    logic        add_ovf;
    logic        sub_ovf;
    logic        slt_bit;
    logic [31:0] alu_res;
    logic        alu_ovf;

    assign accept = in_valid && in_ready;

    // State register; reset drops any in-flight bundle by returning to IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= st_idle;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            st_idle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = st_exec;
                end
            end
            st_exec: begin
                state_nxt = st_hold;
            end
            st_hold: begin
                out_valid = 1'b1;
                // Draining the result frees the operand latch in the same edge.
                in_ready  = out_ready;
                if (out_ready) begin
                    state_nxt = in_valid ? st_exec : st_idle;
                end
            end
            default: begin
                state_nxt = st_idle;
            end
        endcase
    end

    // Operand latch, loaded only on an accepted input transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q <= 3'b000;
            a_q  <= 32'd0;
            b_q  <= 32'd0;
        end else if (accept) begin
            op_q <= in_op;
            a_q  <= in_a;
            b_q  <= in_b;
        end
    end

    // Datapath: one adder and one 33-bit subtractor shared by SUB/SLT/SLTU.
    always_comb begin
        sum      = a_q + b_q;
        diff_ext = {1'b0, a_q} - {1'b0, b_q};
        add_ovf  = (a_q[31] == b_q[31]) && (sum[31] != a_q[31]);
        sub_ovf  = (a_q[31] != b_q[31]) && (diff_ext[31] != a_q[31]);
`ifdef ALU_SLT_OVF_CORRECT_EN
        slt_bit  = diff_ext[31] ^ sub_ovf;
`else
        slt_bit  = diff_ext[31];
`endif
        alu_res  = 32'd0;
        alu_ovf  = 1'b0;
        case (op_q)
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = add_ovf;
            end
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_NOR:  alu_res = ~(a_q | b_q);
            OP_SUB: begin
                alu_res = diff_ext[31:0];
                alu_ovf = sub_ovf;
            end
            OP_SLT: begin
                alu_res = {31'd0, slt_bit};
                alu_ovf = sub_ovf;
            end
            OP_SLTU: begin
                // Borrow out of the unsigned subtraction means a < b.
                alu_res = {31'd0, diff_ext[32]};
            end
            default: begin
                alu_res = 32'd0;
                alu_ovf = 1'b0;
            end
        endcase
    end

    // Result register, written only on leaving EXEC so HOLD keeps it stable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_result <= 32'd0;
            out_zero   <= 1'b0;
            out_ovf    <= 1'b0;
        end else if (state == st_exec) begin
            out_result <= alu_res;
            out_zero   <= (alu_res == 32'd0);
            out_ovf    <= alu_ovf;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed vectors with hand-computed results. The
// stimulus side pushes the expected result on each accepted input; a monitor
// pops and compares on every output transfer.
module tb_alu_issue_stage;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_ovf;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ovf;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   b2b_mode = 0;
    bit   done = 0;

`ifdef ALU_SLT_OVF_CORRECT_EN
    localparam logic [31:0] SLT_RES  = 32'd0;
    localparam logic        SLT_ZERO = 1'b1;
`else
    localparam logic [31:0] SLT_RES  = 32'd1;
    localparam logic        SLT_ZERO = 1'b0;
`endif

    alu_issue_stage dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_ovf    (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: compare every output transfer against the scoreboard.
    initial begin
        int last_cyc = -1;
        while (!done) begin
            @(negedge clk);
            if (!b2b_mode) last_cyc = -1;
            if (reset_n && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", out_result, 32'hxxxxxxxx);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("result", out_result, e.res);
                    chk("zero", {31'd0, out_zero}, {31'd0, e.zero});
                    chk("ovf", {31'd0, out_ovf}, {31'd0, e.ovf});
                end
                if (b2b_mode) begin
                    if (last_cyc >= 0) chk("b2b_spacing", cyc - last_cyc, 2);
                    last_cyc = cyc;
                end
            end
        end
    end

    // Present a bundle from just after a rising edge; returns just after the
    // accepting edge with in_valid still high.
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic z, input logic v);
        bit ok = 0;
        exp_t e;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
        end
        if (ok) begin
            @(posedge clk);
            e.res = r; e.zero = z; e.ovf = v;
            q.push_back(e);
            #1;
        end else begin
            chk("send_timeout", {31'd0, in_ready}, 32'd1);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_op     = 3'b000;
        in_a      = 32'd0;
        in_b      = 32'd0;
        out_ready = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_zero", {31'd0, out_zero}, 32'd0);
        chk("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // SUB overflow with latency: EXEC after the accepting edge, HOLD after the next.
        send(3'b101, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1);
        in_valid = 1'b0;
        chk("lat_exec_no_valid", {31'd0, out_valid}, 32'd0);
        chk("lat_exec_no_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("lat_hold_valid", {31'd0, out_valid}, 32'd1);
        drain();

        // Compare ops, boundaries and logic ops, one at a time.
        send(3'b110, 32'h7FFFFFFF, 32'hFFFFFFFF, SLT_RES, SLT_ZERO, 1'b1);
        in_valid = 1'b0; drain();
        send(3'b111, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0);
        in_valid = 1'b0; drain();
        send(3'b010, 32'hFFFFFFFF, 32'h00000001, 32'd0, 1'b1, 1'b0);
        in_valid = 1'b0; drain();
        send(3'b110, 32'h00000005, 32'h00000005, 32'd0, 1'b1, 1'b0);
        in_valid = 1'b0; drain();
        send(3'b111, 32'hDEADBEEF, 32'hDEADBEEF, 32'd0, 1'b1, 1'b0);
        in_valid = 1'b0; drain();
        send(3'b010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1);
        in_valid = 1'b0; drain();
        send(3'b000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0);
        in_valid = 1'b0; drain();
        send(3'b001, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1'b0);
        in_valid = 1'b0; drain();
        send(3'b100, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        in_valid = 1'b0; drain();
        send(3'b100, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1, 1'b0);
        in_valid = 1'b0; drain();

        // Backpressure: result must sit still while out_ready is low; a
        // competing bundle offered meanwhile must be ignored.
        out_ready = 1'b0;
        send(3'b011, 32'hFFFF0000, 32'hFFFF0000, 32'd0, 1'b1, 1'b0);
        in_op = 3'b010; in_a = 32'h11111111; in_b = 32'h22222222;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_result", out_result, 32'd0);
            chk("bp_zero", {31'd0, out_zero}, 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_released", {31'd0, out_valid}, 32'd0);
        chk("bp_queue", q.size(), 0);
        repeat (2) @(posedge clk);
        #1;

        // Back-to-back: in_valid held high across four bundles.
        b2b_mode = 1;
        send(3'b010, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0);
        send(3'b101, 32'd10, 32'd3, 32'd7, 1'b0, 1'b0);
        send(3'b001, 32'h0000000A, 32'h00000005, 32'h0000000F, 1'b0, 1'b0);
        send(3'b101, 32'd0, 32'd1, 32'hFFFFFFFF, 1'b0, 1'b0);
        in_valid = 1'b0;
        drain();
        b2b_mode = 0;

        // Reset while holding a result: outputs clear without a clock edge.
        out_ready = 1'b0;
        send(3'b010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        chk("pre_rst_result", out_result, 32'd12);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_result", out_result, 32'd0);
        chk("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("async_rst_zero", {31'd0, out_zero}, 32'd0);
        q.delete();
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_idle", {31'd0, out_valid}, 32'd0);
        send(3'b010, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0);
        in_valid = 1'b0;
        drain();

        repeat (3) @(posedge clk);
        done = 1;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
